io_port_controller: RTL and testbench

//  Services the processor's port-mapped I/O bus: IO_port_ID, IO_write_strobe, IO_read_strobe,
//  IO_write_data and IO_read_data. Decodes four ports (UART data, status, control, GPIO) at PORT_BASE+0..3.

---
 rtl/io_port_controller.sv | 145 ++++++++++++++
 tb/tb_io_port_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_controller.sv
// Port-mapped I/O controller: decodes UART data/status/control and GPIO ports at PORT_BASE+0..3,
// buffering UART traffic in TX and RX FIFOs so the processor pipeline never stalls on I/O.
module io_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [7:0]                 wdata,
   output logic [7:0]                 head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop on the same edge frees the slot, so a push at full still lands.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop & ~flush;
   assign head    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; only pointers and counts clear.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end
endmodule

module io_port_controller #(
   parameter int         TX_DEPTH  = 16,
   parameter int         RX_DEPTH  = 16,
   parameter logic [7:0] PORT_BASE = 8'h00
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic [7:0] IO_port_ID,
   input  logic       IO_write_strobe,
   input  logic       IO_read_strobe,
   input  logic [7:0] IO_write_data,
   output logic [7:0] IO_read_data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out
);
   logic [7:0] port_q;
   logic [7:0] wr_off, rd_off, rd_mux, status, tx_head, rx_head;
   logic       wr_hit, rd_hit;
   logic       tx_push, tx_pop, rx_pop, ctl_wr, flush, clr_ovf;
   logic       tx_empty, tx_full, tx_drop, rx_empty, rx_drop;
   logic       tx_ovf, rx_ovf;
   logic       rx_full_unused;
   logic [$clog2(TX_DEPTH):0] tx_count_unused;
   logic [$clog2(RX_DEPTH):0] rx_count_unused;

   // Strobes belong to the instruction whose ID was presented one cycle earlier.
   assign wr_off  = port_q - PORT_BASE;
   assign wr_hit  = (wr_off[7:2] == 6'd0);
   assign rd_off  = IO_port_ID - PORT_BASE;
   assign rd_hit  = (rd_off[7:2] == 6'd0);

   assign tx_push = IO_write_strobe & wr_hit & (wr_off[1:0] == 2'd0);
   assign ctl_wr  = IO_write_strobe & wr_hit & (wr_off[1:0] == 2'd2);
   assign flush   = ctl_wr & IO_write_data[1];
   assign clr_ovf = ctl_wr & IO_write_data[0];
   assign rx_pop  = IO_read_strobe & wr_hit & (wr_off[1:0] == 2'd0);
   assign tx_pop  = tx_valid & tx_ready;

   io_fifo #(.DEPTH(TX_DEPTH)) u_tx (
      .clk(clk100), .rst_n(reset), .push(tx_push), .pop(tx_pop), .flush(flush),
      .wdata(IO_write_data), .head(tx_head), .count(tx_count_unused),
      .empty(tx_empty), .full(tx_full), .drop(tx_drop)
   );

   io_fifo #(.DEPTH(RX_DEPTH)) u_rx (
      .clk(clk100), .rst_n(reset), .push(rx_valid), .pop(rx_pop), .flush(flush),
      .wdata(rx_data), .head(rx_head), .count(rx_count_unused),
      .empty(rx_empty), .full(rx_full_unused), .drop(rx_drop)
   );

   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_head;
   assign status   = {4'b0, tx_ovf, rx_ovf, tx_full, ~rx_empty};

   always_comb begin
      rd_mux = 8'h00;
      if (rd_hit) begin
         case (rd_off[1:0])
            2'd0:    rd_mux = rx_head;
            2'd1:    rd_mux = status;
            2'd3:    rd_mux = gpio_in;
            default: rd_mux = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         port_q       <= 8'h00;
         IO_read_data <= 8'h00;
         gpio_out     <= 8'h00;
         tx_ovf       <= 1'b0;
         rx_ovf       <= 1'b0;
      end else begin
         port_q       <= IO_port_ID;
         IO_read_data <= rd_mux;
         if (IO_write_strobe && wr_hit && wr_off[1:0] == 2'd3) gpio_out <= IO_write_data;
         // A drop on the clearing edge still leaves the flag set.
         tx_ovf <= (tx_ovf & ~clr_ovf) | tx_drop;
         rx_ovf <= (rx_ovf & ~clr_ovf) | rx_drop;
      end
   end
endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: vector table plus hand-written multi-cycle sequences.
module tb_io_port_controller;
   logic       clk100 = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] IO_port_ID = 8'hFF;
   logic       IO_write_strobe = 1'b0;
   logic       IO_read_strobe = 1'b0;
   logic [7:0] IO_write_data = 8'h00;
   logic [7:0] IO_read_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] gpio_in = 8'h3C;
   logic [7:0] gpio_out;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int K_WR = 0, K_RD = 1, K_RX = 2, K_TXC = 3, K_TXP = 4, K_GPC = 5;

   typedef struct {
      int         kind;
      logic [7:0] port;
      logic [7:0] data;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];

   io_port_controller #(.TX_DEPTH(16), .RX_DEPTH(16), .PORT_BASE(8'h00)) dut (
      .clk100(clk100), .reset(reset), .IO_port_ID(IO_port_ID),
      .IO_write_strobe(IO_write_strobe), .IO_read_strobe(IO_read_strobe),
      .IO_write_data(IO_write_data), .IO_read_data(IO_read_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .gpio_in(gpio_in), .gpio_out(gpio_out)
   );

   always #5 clk100 = ~clk100;

   function automatic vec_t mk(input int k, input logic [7:0] p, input logic [7:0] d,
                               input logic [8:0] e);
      vec_t v;
      v.kind = k; v.port = p; v.data = d; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Enter and leave at #1 after a rising edge. ID cycle, then strobe cycle.
   task automatic io_op(input logic [7:0] port, input logic wr, input logic rd,
                        input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                        output logic [7:0] rdat);
      IO_port_ID = port;
      @(posedge clk100); #1;
      rdat = IO_read_data;
      IO_write_strobe = wr; IO_read_strobe = rd; IO_write_data = wd;
      rx_valid = rxv; rx_data = rxd;
      @(posedge clk100); #1;
      IO_write_strobe = 1'b0; IO_read_strobe = 1'b0; rx_valid = 1'b0;
      IO_port_ID = 8'hFF;
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      @(posedge clk100); #1;
      rx_valid = 1'b0;
   endtask

   task automatic tx_pop();
      tx_ready = 1'b1;
      @(posedge clk100); #1;
      tx_ready = 1'b0;
   endtask

   task automatic run_tbl();
      logic [7:0] r;
      foreach (tbl[i]) begin
         case (tbl[i].kind)
            K_WR:  io_op(tbl[i].port, 1'b1, 1'b0, tbl[i].data, 1'b0, 8'h00, r);
            K_RD: begin
               io_op(tbl[i].port, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
               chk($sformatf("vec%0d_rd_p%0h", i, tbl[i].port), {1'b0, r}, tbl[i].exp);
            end
            K_RX:  rx_pulse(tbl[i].data);
            K_TXC: chk($sformatf("vec%0d_tx", i), {tx_valid, tx_data}, tbl[i].exp);
            K_TXP: tx_pop();
            K_GPC: chk($sformatf("vec%0d_gpio", i), {1'b0, gpio_out}, tbl[i].exp);
            default: ;
         endcase
      end
      tbl.delete();
   endtask

   initial begin
      logic [7:0] r;

      // Reset state
      repeat (2) @(posedge clk100);
      #1;
      chk("rst_rd",   {1'b0, IO_read_data}, 9'h000);
      chk("rst_tx",   {tx_valid, tx_data},  9'h000);
      chk("rst_gpio", {1'b0, gpio_out},     9'h000);
      reset = 1'b1;
      @(posedge clk100); #1;

      // TX basic push/pop, overflow, drain order; RX order; GPIO
      tbl.push_back(mk(K_WR,  8'h00, 8'h41, 9'h000));
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h141));
      tbl.push_back(mk(K_TXP, 8'h00, 8'h00, 9'h000));
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h000));
      for (int i = 1; i <= 17; i++) tbl.push_back(mk(K_WR, 8'h00, 8'(i), 9'h000));
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h101));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h00A));
      tbl.push_back(mk(K_WR,  8'h02, 8'h01, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h002));
      for (int i = 1; i <= 16; i++) begin
         tbl.push_back(mk(K_TXC, 8'h00, 8'h00, {1'b1, 8'(i)}));
         tbl.push_back(mk(K_TXP, 8'h00, 8'h00, 9'h000));
      end
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h000));
      tbl.push_back(mk(K_RX,  8'h00, 8'h11, 9'h000));
      tbl.push_back(mk(K_RX,  8'h00, 8'h22, 9'h000));
      tbl.push_back(mk(K_RX,  8'h00, 8'h33, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h001));
      tbl.push_back(mk(K_RD,  8'h00, 8'h00, 9'h011));
      tbl.push_back(mk(K_RD,  8'h00, 8'h00, 9'h022));
      tbl.push_back(mk(K_RD,  8'h00, 8'h00, 9'h033));
      tbl.push_back(mk(K_RD,  8'h00, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h02, 8'h00, 9'h000));
      tbl.push_back(mk(K_WR,  8'h03, 8'hA5, 9'h000));
      tbl.push_back(mk(K_GPC, 8'h00, 8'h00, 9'h0A5));
      tbl.push_back(mk(K_RD,  8'h03, 8'h00, 9'h03C));
      run_tbl();

      // RX full with a coincident pop: push must land, no overflow
      for (int i = 0; i < 16; i++) rx_pulse(8'h80 + 8'(i));
      io_op(8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("rxfull_status", {1'b0, r}, 9'h001);
      io_op(8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'hEE, r);
      chk("rxfull_coinc_rd", {1'b0, r}, 9'h080);
      io_op(8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("rxfull_no_ovf", {1'b0, r}, 9'h001);
      rx_pulse(8'hFF);
      io_op(8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("rx_ovf_set", {1'b0, r}, 9'h005);
      for (int i = 1; i < 16; i++) begin
         io_op(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
         chk($sformatf("rx_drain%0d", i), {1'b0, r}, {1'b0, 8'h80 + 8'(i)});
      end
      io_op(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("rx_drain_last", {1'b0, r}, 9'h0EE);
      io_op(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("rx_drain_empty", {1'b0, r}, 9'h000);
      io_op(8'h02, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, r);
      io_op(8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("rx_ovf_clr", {1'b0, r}, 9'h000);

      // Asynchronous reset in the middle of a TX burst
      rx_pulse(8'h5C);
      io_op(8'h00, 1'b1, 1'b0, 8'h70, 1'b0, 8'h00, r);
      io_op(8'h00, 1'b1, 1'b0, 8'h71, 1'b0, 8'h00, r);
      IO_port_ID = 8'h00;
      @(posedge clk100); #1;
      chk("pre_rst_rd", {1'b0, IO_read_data}, 9'h05C);
      chk("pre_rst_tx", {tx_valid, tx_data}, 9'h170);
      IO_write_strobe = 1'b1; IO_write_data = 8'h77;
      #2 reset = 1'b0;
      #1;
      chk("midrst_rd",   {1'b0, IO_read_data}, 9'h000);
      chk("midrst_tx",   {tx_valid, tx_data},  9'h000);
      chk("midrst_gpio", {1'b0, gpio_out},     9'h000);
      IO_write_strobe = 1'b0; IO_port_ID = 8'hFF;
      @(posedge clk100); #1;
      chk("rst_held_tx", {tx_valid, tx_data}, 9'h000);
      reset = 1'b1;
      @(posedge clk100); #1;
      io_op(8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("postrst_status", {1'b0, r}, 9'h000);
      io_op(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, r);
      chk("postrst_rx", {1'b0, r}, 9'h000);

      // Flush with both FIFOs partially full; out-of-range ports do nothing
      tbl.push_back(mk(K_WR,  8'h03, 8'h5A, 9'h000));
      tbl.push_back(mk(K_WR,  8'h00, 8'h99, 9'h000));
      tbl.push_back(mk(K_WR,  8'h06, 8'h03, 9'h000));
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h199));
      tbl.push_back(mk(K_WR,  8'h07, 8'h11, 9'h000));
      tbl.push_back(mk(K_GPC, 8'h00, 8'h00, 9'h05A));
      tbl.push_back(mk(K_WR,  8'h00, 8'h9A, 9'h000));
      tbl.push_back(mk(K_RX,  8'h00, 8'h31, 9'h000));
      tbl.push_back(mk(K_RX,  8'h00, 8'h32, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h001));
      tbl.push_back(mk(K_WR,  8'h02, 8'h02, 9'h000));
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h00, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h000));
      tbl.push_back(mk(K_WR,  8'h04, 8'h66, 9'h000));
      tbl.push_back(mk(K_TXC, 8'h00, 8'h00, 9'h000));
      tbl.push_back(mk(K_GPC, 8'h00, 8'h00, 9'h05A));
      tbl.push_back(mk(K_RX,  8'h00, 8'h44, 9'h000));
      tbl.push_back(mk(K_RD,  8'h04, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h05, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h07, 8'h00, 9'h000));
      tbl.push_back(mk(K_RD,  8'h01, 8'h00, 9'h001));
      tbl.push_back(mk(K_RD,  8'h00, 8'h00, 9'h044));
      run_tbl();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
